// File: rtl/oob_write_cmd_queue.sv
// rtl/oob_write_cmd_queue.sv - show-ahead write request queue with push-time range classification and OOB accounting
module oob_write_cmd_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int VEC_SIZE = 8,
  parameter int ARR_SIZE = 4,
  parameter int DROP_OOB = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [ADDR_W-1:0]          i_req_addr,
  input  logic [DATA_W-1:0]          i_req_data,
  input  logic                       i_drain_en,
  output logic                       o_wr_valid,
  output logic [ADDR_W-1:0]          o_addr_write,
  output logic [DATA_W-1:0]          o_data_write,
  output logic                       o_vec_in_range,
  output logic                       o_arr_in_range,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [7:0]                 o_oob_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              vec_mem  [DEPTH];
  logic              arr_mem  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [7:0]        oob_count;

  logic [31:0]       addr_ext;
  logic              vec_ok;
  logic              arr_ok;
  logic              push;
  logic              store;
  logic              pop;
  logic              full;
  logic              empty;

  // Compare in a wide unsigned domain so any SIZE/ADDR_W combination is exact.
  assign addr_ext = 32'(i_req_addr);
  assign vec_ok   = addr_ext < 32'(VEC_SIZE);
  assign arr_ok   = addr_ext < 32'(ARR_SIZE);

  assign full        = (level == LVL_W'(DEPTH));
  assign empty       = (level == '0);
  assign o_req_ready = !rst && !full;

  assign push  = i_req_valid && o_req_ready;
  assign store = push && (vec_ok || (DROP_OOB == 0));
  assign pop   = !empty && i_drain_en;

  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[wr_ptr] <= i_req_addr;
      data_mem[wr_ptr] <= i_req_data;
      vec_mem[wr_ptr]  <= vec_ok;
      arr_mem[wr_ptr]  <= vec_ok && arr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      oob_count <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // A dropped push never touches the level, so it can only move by the store/pop pair.
      case ({store, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (push && !vec_ok && (oob_count != 8'hFF)) begin
        oob_count <= oob_count + 8'd1;
      end
    end
  end

  // Storage is not cleared by reset, so the head is masked while the queue is empty.
  assign o_wr_valid     = !empty;
  assign o_addr_write   = empty ? '0 : addr_mem[rd_ptr];
  assign o_data_write   = empty ? '0 : data_mem[rd_ptr];
  assign o_vec_in_range = empty ? 1'b0 : vec_mem[rd_ptr];
  assign o_arr_in_range = empty ? 1'b0 : arr_mem[rd_ptr];
  assign o_level        = level;
  assign o_oob_count    = oob_count;

endmodule
